serial_frame_receiver: RTL

//  Front end of the binarized-image input path, running on serialClock beside the input shift register.

---
 rtl/nn_serial_pkg.sv | 18 +
 rtl/sync_word_detector.sv | 42 ++++
 rtl/serial_frame_receiver.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nn_serial_pkg.sv
// Shared definitions for the binarized-image serial input path.
//   rx_state_t          : receiver FSM states (HUNT, PAYLOAD, CHECK)
//   SYNC_WORD_DEFAULT   : frame sync pattern, transmitted MSB first
//   SYNC_WIDTH_DEFAULT  : sync pattern length in bits
//   CHK_WIDTH_DEFAULT   : checksum width; checksum = popcount(payload) mod 2**width
package nn_serial_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } rx_state_t;

  localparam int          SYNC_WIDTH_DEFAULT = 16;
  localparam logic [15:0] SYNC_WORD_DEFAULT  = 16'hA5C3;
  localparam int          CHK_WIDTH_DEFAULT  = 8;

endpackage

// File: rtl/sync_word_detector.sv
// Sliding-window sync word detector.
// Ports:
//   serialClock  in   bit clock, rising edge
//   reset        in   asynchronous, active-high; clears the window
//   serialData   in   incoming serial bit
//   enable       in   shift the window by one bit this edge
//   clear        in   zero the window (takes priority over enable)
//   matchNext    out  combinational: the window after this edge's shift
//                     equals syncWord (only when enable=1)
module sync_word_detector
  import nn_serial_pkg::*;
#(
  parameter int                   syncWidth = SYNC_WIDTH_DEFAULT,
  parameter logic [syncWidth-1:0] syncWord  = SYNC_WORD_DEFAULT
) (
  input  logic serialClock,
  input  logic reset,
  input  logic serialData,
  input  logic enable,
  input  logic clear,
  output logic matchNext
);

  logic [syncWidth-1:0] window;
  logic [syncWidth-1:0] windowNext;

  // Every bit position is a candidate start, so the full window is compared
  // on each enabled bit; overlapping sync candidates are found naturally.
  assign windowNext = {window[syncWidth-2:0], serialData};
  assign matchNext  = enable && (windowNext == syncWord);

  always_ff @(posedge serialClock or posedge reset) begin
    if (reset) begin
      window <= '0;
    end else if (clear) begin
      window <= '0;
    end else if (enable) begin
      window <= windowNext;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts for a sync word, collects numInputs payload
// bits plus a chkWidth-bit checksum (popcount of the payload, MSB first) and
// presents verified frames on a valid/ready output.
// Ports:
//   reset         in   asynchronous, active-high; clears all state
//   serialClock   in   bit clock, rising edge
//   serialData    in   serial bit, sampled when serialEnable=1
//   serialEnable  in   bit qualifier; 0 = no bit this cycle, state holds
//   frameReady    in   downstream accepts frameData
//   frameValid    out  frameData holds a verified frame
//   frameData     out  payload; first bit received sits at [numInputs-1]
//   frameError    out  one-cycle pulse on checksum mismatch
//   overrun       out  sticky; good frame dropped because holding reg full
//   busy          out  1 while in PAYLOAD or CHECK
//
// Handshake: a transfer happens on any rising edge where frameValid and
// frameReady are both 1; frameValid then drops unless a new verified frame
// completes on the same edge, in which case it is loaded and frameValid
// stays high. frameData never changes while frameValid=1 and not transferred.
// frameReady while frameValid=0 is ignored.
module serial_frame_receiver
  import nn_serial_pkg::*;
#(
  parameter int                   numInputs = 784,
  parameter int                   syncWidth = SYNC_WIDTH_DEFAULT,
  parameter logic [syncWidth-1:0] syncWord  = SYNC_WORD_DEFAULT,
  parameter int                   chkWidth  = CHK_WIDTH_DEFAULT
) (
  input  logic                 reset,
  input  logic                 serialClock,
  input  logic                 serialData,
  input  logic                 serialEnable,
  input  logic                 frameReady,
  output logic                 frameValid,
  output logic [numInputs-1:0] frameData,
  output logic                 frameError,
  output logic                 overrun,
  output logic                 busy
);

  localparam int cntW    = $clog2(numInputs);
  localparam int popW    = $clog2(numInputs + 1);
  localparam int chkCntW = (chkWidth > 1) ? $clog2(chkWidth) : 1;
  // Popcount is zero-extended to at least chkWidth so the mod-2**chkWidth
  // truncation is legal even for small payloads.
  localparam int extW    = (popW > chkWidth) ? popW : chkWidth;

  localparam logic [cntW-1:0]    LAST_BIT = cntW'(numInputs - 1);
  localparam logic [chkCntW-1:0] LAST_CHK = chkCntW'(chkWidth - 1);

  rx_state_t            state;
  rx_state_t            stateNext;
  logic [cntW-1:0]      bitCount;
  logic [chkCntW-1:0]   chkCount;
  logic [numInputs-1:0] payload;
  logic [popW-1:0]      popCount;
  logic [chkWidth-2:0]  chkShift;

  logic                 syncMatch;
  logic                 payloadLast;
  logic                 checkLast;
  logic [chkWidth-1:0]  chkFinal;
  logic [extW-1:0]      popExt;
  logic                 chkMatch;
  logic                 handoff;

  sync_word_detector #(
    .syncWidth (syncWidth),
    .syncWord  (syncWord)
  ) u_sync (
    .serialClock (serialClock),
    .reset       (reset),
    .serialData  (serialData),
    .enable      (serialEnable && (state == HUNT)),
    .clear       (checkLast),
    .matchNext   (syncMatch)
  );

  assign chkFinal = {chkShift, serialData};
  assign popExt   = extW'(popCount);
  assign chkMatch = (chkFinal == popExt[chkWidth-1:0]);
  assign handoff  = frameValid && frameReady;

  always_comb begin
    stateNext   = state;
    payloadLast = 1'b0;
    checkLast   = 1'b0;
    case (state)
      HUNT: begin
        if (syncMatch) stateNext = PAYLOAD;
      end
      PAYLOAD: begin
        if (serialEnable && (bitCount == LAST_BIT)) begin
          payloadLast = 1'b1;
          stateNext   = CHECK;
        end
      end
      CHECK: begin
        if (serialEnable && (chkCount == LAST_CHK)) begin
          checkLast = 1'b1;
          stateNext = HUNT;
        end
      end
      default: stateNext = HUNT;
    endcase
  end

  always_ff @(posedge serialClock or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      busy       <= 1'b0;
      bitCount   <= '0;
      chkCount   <= '0;
      payload    <= '0;
      popCount   <= '0;
      chkShift   <= '0;
      frameData  <= '0;
      frameValid <= 1'b0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= stateNext;
      busy       <= (stateNext != HUNT);
      frameError <= 1'b0;

      if (handoff) frameValid <= 1'b0;

      if (serialEnable) begin
        case (state)
          HUNT: begin
            if (syncMatch) begin
              bitCount <= '0;
              popCount <= '0;
              payload  <= '0;
            end
          end
          PAYLOAD: begin
            payload  <= {payload[numInputs-2:0], serialData};
            popCount <= popCount + popW'(serialData);
            bitCount <= bitCount + cntW'(1);
            if (payloadLast) chkCount <= '0;
          end
          CHECK: begin
            chkShift <= chkFinal[chkWidth-2:0];
            chkCount <= chkCount + chkCntW'(1);
            if (checkLast) begin
              if (!chkMatch) begin
                frameError <= 1'b1;
              end else if (!frameValid || frameReady) begin
                // Also covers the same-edge handoff: reload keeps valid high.
                frameData  <= payload;
                frameValid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
